// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: turns a MEM-stage load/store into one valid/ready bus transaction and stalls the core until the response.
// Latency: at least 3 stall cycles; valid held until ready; optional WAIT_RSP timeout under DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_core_addr,
  input  logic [WIDTH-1:0] i_core_wdata,
  input  logic [3:0]       i_core_byteen,
  input  logic             i_core_we,
  input  logic             i_core_re,
  output logic [WIDTH-1:0] o_core_rdata,
  output logic             o_core_stall,
  output logic             o_fault,
  output logic             o_bus_req_valid,
  input  logic             i_bus_req_ready,
  output logic [WIDTH-1:0] o_bus_addr,
  output logic [WIDTH-1:0] o_bus_wdata,
  output logic [3:0]       o_bus_wstrb,
  output logic             o_bus_we,
  input  logic             i_bus_rsp_valid,
  input  logic [WIDTH-1:0] i_bus_rsp_data,
  input  logic             i_bus_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       byteen;
    logic             we;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             stall;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall   = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_core_we || i_core_re) begin
          stall        = 1'b1;
          req_d.addr   = i_core_addr;
          req_d.wdata  = i_core_wdata;
          req_d.byteen = i_core_byteen;
          // we wins when both strobes are set, so a combined request is a store
          req_d.we     = i_core_we;
          state_d      = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (i_bus_req_ready) begin
          state_d = WAIT_RSP;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (i_bus_rsp_valid) begin
          rdata_d = (i_bus_rsp_err || req_q.we) ? '0 : i_bus_rsp_data;
          err_d   = i_bus_rsp_err;
          state_d = DONE;
        end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // Unconditional return; the core request still asserted here is the one just served.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_core_stall    = stall;
  assign o_core_rdata    = rdata_q;
  assign o_fault         = (state_q == DONE) && err_q;
  assign o_bus_req_valid = (state_q == REQ);
  assign o_bus_addr      = req_q.addr;
  assign o_bus_wdata     = req_q.wdata;
  assign o_bus_wstrb     = req_q.we ? req_q.byteen : 4'b1111;
  assign o_bus_we        = req_q.we;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: directed transactions push expected bus requests and core completions.
module tb_dmem_bus_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_byteen;
  logic        core_we, core_re;
  logic [31:0] core_rdata;
  logic        core_stall, fault;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_we;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        bus_rsp_err;

  dmem_bus_bridge #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_core_addr(core_addr), .i_core_wdata(core_wdata), .i_core_byteen(core_byteen),
    .i_core_we(core_we), .i_core_re(core_re),
    .o_core_rdata(core_rdata), .o_core_stall(core_stall), .o_fault(fault),
    .o_bus_req_valid(bus_req_valid), .i_bus_req_ready(bus_req_ready),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb), .o_bus_we(bus_we),
    .i_bus_rsp_valid(bus_rsp_valid), .i_bus_rsp_data(bus_rsp_data), .i_bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          stalls;
  } cpl_exp_t;

  bus_exp_t bus_q[$];
  cpl_exp_t cpl_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: bus handshakes, request stability, and completions (stall falling edge out of reset)
  logic        prev_stall = 1'b0, prev_rst = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [68:0] prev_fields = '0;
  logic        after_done = 1'b0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    bus_exp_t b;
    cpl_exp_t c;
    if (!rst_n) begin
      stall_cnt  = 0;
      after_done = 1'b0;
    end else begin
      if (after_done) chk("fault_pulse_width", {127'd0, fault}, 128'd0);
      after_done = 1'b0;
      if (prev_rst && prev_stall && !core_stall) begin
        if (cpl_q.size() == 0) begin
          fail_now("unexpected_completion");
        end else begin
          c = cpl_q.pop_front();
          chk("cpl_rdata", {96'd0, core_rdata}, {96'd0, c.rdata});
          chk("cpl_fault", {127'd0, fault}, {127'd0, c.fault});
          chk("cpl_stall_cycles", 128'(stall_cnt), 128'(c.stalls));
        end
        stall_cnt  = 0;
        after_done = 1'b1;
      end else if (fault) begin
        chk("spurious_fault", {127'd0, fault}, 128'd0);
      end
      if (core_stall) stall_cnt++;
      if (prev_rst && prev_vld && !prev_rdy)
        chk("req_held_stable", {59'd0, bus_req_valid, bus_addr, bus_wdata, bus_wstrb, bus_we},
            {59'd0, 1'b1, prev_fields});
      if (bus_req_valid && bus_req_ready) begin
        if (bus_q.size() == 0) begin
          fail_now("unexpected_bus_req");
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr",  {96'd0, bus_addr},  {96'd0, b.addr});
          chk("bus_wdata", {96'd0, bus_wdata}, {96'd0, b.wdata});
          chk("bus_wstrb", {124'd0, bus_wstrb}, {124'd0, b.wstrb});
          chk("bus_we",    {127'd0, bus_we},    {127'd0, b.we});
        end
      end
    end
    prev_rst    = rst_n;
    prev_stall  = core_stall;
    prev_vld    = bus_req_valid;
    prev_rdy    = bus_req_ready;
    prev_fields = {bus_addr, bus_wdata, bus_wstrb, bus_we};
  end

  task automatic push_exp(input logic [31:0] addr, wdata, input logic [3:0] wstrb, input logic we);
    bus_exp_t b;
    b.addr = addr; b.wdata = wdata; b.wstrb = wstrb; b.we = we;
    bus_q.push_back(b);
  endtask

  task automatic push_cpl(input logic [31:0] rdata, input logic f, input int stalls);
    cpl_exp_t c;
    c.rdata = rdata; c.fault = f; c.stalls = stalls;
    cpl_q.push_back(c);
  endtask

  task automatic drive_core(input logic [31:0] addr, wdata, input logic [3:0] be, input logic we, re);
    core_addr = addr; core_wdata = wdata; core_byteen = be; core_we = we; core_re = re;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus_req_valid && n < 20);
    if (!bus_req_valid) fail_now("req_valid_wait");
  endtask

  task automatic wait_unstall();
    int n = 0;
    while (core_stall && n < 50) begin @(posedge clk); #1; n++; end
    if (core_stall) fail_now("stall_release_wait");
  endtask

  // Called at posedge+1 with the bridge idle (or in DONE); returns at posedge+1 of DONE.
  task automatic do_txn(input logic [31:0] addr, wdata, input logic [3:0] be, input logic we, re,
                        input int rdly, sdly, input logic [31:0] rsp_d, input logic rsp_e,
                        input logic [3:0] exp_wstrb, input logic exp_we,
                        input logic [31:0] exp_rd, input logic exp_f, input int exp_st);
    push_exp(addr, wdata, exp_wstrb, exp_we);
    push_cpl(exp_rd, exp_f, exp_st);
    drive_core(addr, wdata, be, we, re);
    wait_valid();
    repeat (rdly) begin
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h5A5A5A5A; bus_rsp_err = 1'b1;
      @(posedge clk); #1;
    end
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    repeat (sdly) begin @(posedge clk); #1; end
    bus_rsp_valid = 1'b1; bus_rsp_data = rsp_d; bus_rsp_err = rsp_e;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    wait_unstall();
    drive_core('0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_core('0, '0, '0, 1'b0, 1'b0);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    #3;
    chk("rst_req_valid", {127'd0, bus_req_valid}, 128'd0);
    chk("rst_rdata",     {96'd0, core_rdata},     128'd0);
    chk("rst_fault",     {127'd0, fault},         128'd0);
    chk("rst_stall_idle", {127'd0, core_stall},   128'd0);
    core_re = 1'b1; #1;
    chk("rst_stall_req", {127'd0, core_stall}, 128'd1);
    core_re = 1'b0; #1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // load, immediate ready and response: 3 stall cycles
    do_txn(32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 3);
    // store with ready low 4 cycles; ack data must not reach rdata
    do_txn(32'h204, 32'h12345678, 4'b0011, 1'b1, 1'b0, 4, 0, 32'hCAFEF00D, 1'b0, 4'b0011, 1'b1, 32'h0, 1'b0, 7);
    // we and re together is a single store; response two cycles late
    do_txn(32'h308, 32'hA5A5A5A5, 4'b1100, 1'b1, 1'b1, 0, 2, 32'h99999999, 1'b0, 4'b1100, 1'b1, 32'h0, 1'b0, 5);
    // back-to-back load then store
    do_txn(32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 0, 0, 32'h11223344, 1'b0, 4'hF, 1'b0, 32'h11223344, 1'b0, 3);
    do_txn(32'h44, 32'h55667788, 4'hF, 1'b1, 1'b0, 1, 0, 32'h0, 1'b0, 4'hF, 1'b1, 32'h0, 1'b0, 4);
    // error response zeroes rdata and pulses fault
    do_txn(32'h500, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'hFFFFFFFF, 1'b1, 4'hF, 1'b0, 32'h0, 1'b1, 3);
    // unaligned load: address passes through, read strobe is all ones despite byteen
    do_txn(32'h103, 32'h0, 4'h1, 1'b0, 1'b1, 0, 0, 32'h0BADF00D, 1'b0, 4'hF, 1'b0, 32'h0BADF00D, 1'b0, 3);

    // response while idle is ignored; rdata holds
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h77777777; bus_rsp_err = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    @(posedge clk); #1;
    chk("idle_rsp_rdata_hold", {96'd0, core_rdata}, {96'd0, 32'h0BADF00D});
    chk("idle_rsp_fault",      {127'd0, fault},     128'd0);
    chk("idle_rsp_stall",      {127'd0, core_stall}, 128'd0);
    chk("idle_rsp_valid",      {127'd0, bus_req_valid}, 128'd0);

    // reset during WAIT_RSP abandons the load; late response ignored
    push_exp(32'h700, 32'h0, 4'hF, 1'b0);
    drive_core(32'h700, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_valid();
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_core('0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("midrst_valid", {127'd0, bus_req_valid}, 128'd0);
    chk("midrst_rdata", {96'd0, core_rdata},     128'd0);
    chk("midrst_stall", {127'd0, core_stall},    128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h13572468; bus_rsp_err = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("late_rsp_rdata", {96'd0, core_rdata},     128'd0);
    chk("late_rsp_fault", {127'd0, fault},         128'd0);
    chk("late_rsp_stall", {127'd0, core_stall},    128'd0);
    chk("late_rsp_valid", {127'd0, bus_req_valid}, 128'd0);
    do_txn(32'h104, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'h0F0F0F0F, 1'b0, 4'hF, 1'b0, 32'h0F0F0F0F, 1'b0, 3);

    // no response at all
    push_exp(32'h600, 32'h0, 4'hF, 1'b0);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    push_cpl(32'h0, 1'b1, 2 + TO);
`endif
    drive_core(32'h600, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_valid();
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    wait_unstall();
    drive_core('0, '0, '0, 1'b0, 1'b0);
`else
    repeat (40) begin @(posedge clk); #1; end
    chk("no_rsp_stall_held", {127'd0, core_stall}, 128'd1);
    chk("no_rsp_valid_low",  {127'd0, bus_req_valid}, 128'd0);
    rst_n = 1'b0;
    drive_core('0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    repeat (3) begin @(posedge clk); #1; end

    chk("bus_q_drained", 128'(bus_q.size()), 128'd0);
    chk("cpl_q_drained", 128'(cpl_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT_RSP cycles before a timeout; used only with REQ-030.
REQ-003 SHALL have ports i_clk input 1, the only clock; i_reset_n input 1, asynchronous active-low reset.
REQ-004 SHALL have core-side ports: i_core_addr input WIDTH; i_core_wdata input WIDTH; i_core_byteen input 4; i_core_we input 1; i_core_re input 1 (the MEM-stage dmem request).
REQ-005 SHALL have core-side ports: o_core_rdata output WIDTH, load data; o_core_stall output 1, freeze-pipeline request; o_fault output 1, one-cycle error pulse.
REQ-006 SHALL have bus request ports: o_bus_req_valid output 1; i_bus_req_ready input 1; o_bus_addr output WIDTH; o_bus_wdata output WIDTH; o_bus_wstrb output 4; o_bus_we output 1.
REQ-007 SHALL have bus response ports: i_bus_rsp_valid input 1; i_bus_rsp_data input WIDTH; i_bus_rsp_err input 1.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_RSP, DONE.
REQ-009 IDLE: request = i_core_we | i_core_re; if request, o_core_stall SHALL be 1 combinationally that cycle, addr/wdata/byteen/we SHALL be latched, next state REQ.
REQ-010 i_core_we and i_core_re both high SHALL be treated as a write; read ignored.
REQ-011 REQ: o_bus_req_valid=1 with latched fields held stable; on i_bus_req_ready=1 next state WAIT_RSP; valid SHALL NOT drop before ready.
REQ-012 WAIT_RSP: o_bus_req_valid=0; i_bus_rsp_valid SHALL be ignored in every state except WAIT_RSP; on i_bus_rsp_valid capture i_bus_rsp_data (loads) and i_bus_rsp_err, next state DONE.
REQ-013 Stores SHALL also wait for i_bus_rsp_valid (write ack); captured data for stores SHALL be 0.
REQ-014 o_core_stall SHALL be 1 in REQ and WAIT_RSP, 0 in DONE and 0 in IDLE without request.
REQ-015 DONE: o_core_rdata = captured data (0 if error); o_fault = captured error; lasts exactly one cycle; next state IDLE unconditionally, so the still-present core request is not reissued.
REQ-016 o_core_rdata SHALL hold its last value outside DONE; o_fault SHALL be 0 outside DONE.
REQ-017 o_bus_wstrb SHALL equal latched byteen for writes and 4'b1111 for reads; o_bus_addr passed unmodified (no alignment applied).
REQ-018 Minimum load/store latency: request seen in IDLE cycle N, ready at N+1, rsp at N+2, DONE at N+3 (3 stall cycles).

Reset
REQ-019 On i_reset_n low, asynchronously: state IDLE, o_bus_req_valid 0, o_core_rdata 0, o_fault 0, latched fields 0, timeout counter 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it; responses arriving after reset release while in IDLE SHALL be ignored.
REQ-021 o_core_stall SHALL be 0 during reset unless a core request is present (combinational rule of REQ-009 still applies).

Configuration
REQ-030 With DMEM_BRIDGE_TIMEOUT_EN defined: a counter SHALL count WAIT_RSP cycles; reaching TIMEOUT_CYCLES without i_bus_rsp_valid SHALL force DONE with data 0 and o_fault=1; counter cleared on entering WAIT_RSP.
REQ-031 Without DMEM_BRIDGE_TIMEOUT_EN: no counter logic; WAIT_RSP waits indefinitely.

Verification
REQ-040 Load addr 0x100, ready immediate, rsp data 0xDEADBEEF next cycle -> stall high 3 cycles, DONE rdata 0xDEADBEEF, fault 0.
REQ-041 Store addr 0x204 wdata 0x12345678 byteen 4'b0011, ready held low 4 cycles -> valid and fields stable 5 cycles, wstrb 4'b0011, ack releases stall after DONE.
REQ-042 we=re=1 -> o_bus_we=1, single transaction; back-to-back load then store -> two distinct transactions, no duplicate.
REQ-043 Load with rsp_err=1, rsp_data 0xFFFFFFFF -> DONE rdata 0, o_fault pulse exactly 1 cycle.
REQ-044 i_reset_n low during WAIT_RSP, late rsp_valid after release -> state IDLE, no fault, no DONE, rdata 0.
REQ-045 With DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> DONE after 8 WAIT_RSP cycles, fault 1, rdata 0; without macro -> stall held indefinitely.
